// File: rtl/ysyx_22050133_lsu_pkg.sv
// Shared constants and state type for the ysyx_22050133 load/store unit.
// Covers the funct3 encodings, exception codes and AXI size codes.
package ysyx_22050133_lsu_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b10;

  localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_1 = 3'd0;
  localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_2 = 3'd1;
  localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_4 = 3'd2;
  localparam logic [2:0] ysyx_22050133_AXI_SIZE_BYTES_8 = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/ysyx_22050133_lsu_if.sv
// Bundle of the EXU-side, WBU-side and cache-side handshakes around the LSU.
// master is the LSU itself; slave is whatever surrounds it.
interface ysyx_22050133_lsu_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int RD_WIDTH   = 5
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [ADDR_WIDTH-1:0] in_addr_i;
  logic                  in_we_i;
  logic [2:0]            in_funct3_i;
  logic [DATA_WIDTH-1:0] in_wdata_i;
  logic [RD_WIDTH-1:0]   in_rd_i;

  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_rdata_o;
  logic [RD_WIDTH-1:0]   out_rd_o;
  logic [1:0]            out_exc_o;

  logic                  rw_addr_valid_o;
  logic                  rw_addr_ready_i;
  logic [ADDR_WIDTH-1:0] rw_addr_o;
  logic                  rw_we_o;
  logic [2:0]            rw_size_o;
  logic                  rw_if_o;
  logic [DATA_WIDTH-1:0] w_data_o;
  logic                  rw_data_valid_i;
  logic                  r_data_ready_o;
  logic [DATA_WIDTH-1:0] r_data_i;

  modport master (
    input  in_valid_i, in_addr_i, in_we_i, in_funct3_i, in_wdata_i, in_rd_i,
    output in_ready_o,
    output out_valid_o, out_rdata_o, out_rd_o, out_exc_o,
    input  out_ready_i,
    output rw_addr_valid_o, rw_addr_o, rw_we_o, rw_size_o, rw_if_o, w_data_o,
    input  rw_addr_ready_i,
    input  rw_data_valid_i, r_data_i,
    output r_data_ready_o
  );

  modport slave (
    output in_valid_i, in_addr_i, in_we_i, in_funct3_i, in_wdata_i, in_rd_i,
    input  in_ready_o,
    input  out_valid_o, out_rdata_o, out_rd_o, out_exc_o,
    output out_ready_i,
    input  rw_addr_valid_o, rw_addr_o, rw_we_o, rw_size_o, rw_if_o, w_data_o,
    output rw_addr_ready_i,
    output rw_data_valid_i, r_data_i,
    input  r_data_ready_o
  );
endinterface

// File: rtl/ysyx_22050133_lsu_fmt.sv
// Combinational helpers for the LSU: legality/alignment check and store masking
// on the incoming op, plus size-masking and sign/zero extension of returned load data.
module ysyx_22050133_lsu_fmt
  import ysyx_22050133_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [2:0]            chk_addr,
  input  logic                  chk_we,
  input  logic [2:0]            chk_funct3,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic [1:0]            exc,
  output logic [DATA_WIDTH-1:0] st_masked,
  input  logic [2:0]            ld_funct3,
  input  logic [DATA_WIDTH-1:0] ld_raw,
  output logic [DATA_WIDTH-1:0] ld_ext
);

  logic ld_signed;
  assign ld_signed = ~ld_funct3[2];

  // Illegal encodings win over misalignment, so check them first.
  always_comb begin
    exc = EXC_NONE;
    if (chk_funct3 == F3_BAD || (chk_we && chk_funct3[2])) begin
      exc = EXC_ILLEGAL;
    end else begin
      case (chk_funct3[1:0])
        2'b01:   if (chk_addr[0] != 1'b0)    exc = EXC_MISALIGN;
        2'b10:   if (chk_addr[1:0] != 2'b00) exc = EXC_MISALIGN;
        2'b11:   if (chk_addr != 3'b000)     exc = EXC_MISALIGN;
        default: exc = EXC_NONE;
      endcase
    end
  end

  always_comb begin
    st_masked = st_data;
    case (chk_funct3[1:0])
      2'b00:   st_masked = {{(DATA_WIDTH-8){1'b0}},  st_data[7:0]};
      2'b01:   st_masked = {{(DATA_WIDTH-16){1'b0}}, st_data[15:0]};
      2'b10:   st_masked = {{(DATA_WIDTH-32){1'b0}}, st_data[31:0]};
      default: st_masked = st_data;
    endcase
  end

  always_comb begin
    ld_ext = ld_raw;
    case (ld_funct3[1:0])
      2'b00:   ld_ext = {{(DATA_WIDTH-8){ld_signed & ld_raw[7]}},   ld_raw[7:0]};
      2'b01:   ld_ext = {{(DATA_WIDTH-16){ld_signed & ld_raw[15]}}, ld_raw[15:0]};
      2'b10:   ld_ext = {{(DATA_WIDTH-32){ld_signed & ld_raw[31]}}, ld_raw[31:0]};
      default: ld_ext = ld_raw;
    endcase
  end

endmodule

// File: rtl/ysyx_22050133_lsu.sv
// Load/store unit: one op at a time from EXU, single-beat cache request,
// extended result handed to WBU. All outputs come straight from registers.
module ysyx_22050133_lsu
  import ysyx_22050133_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int RD_WIDTH   = 5
) (
  input logic              clk,
  input logic              rst,
  ysyx_22050133_lsu_if.master bus
);

  lsu_state_e            state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  rw_valid_q, rw_valid_d;
  logic                  rdy_q, rdy_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_rdata_q, out_rdata_d;
  logic [RD_WIDTH-1:0]   out_rd_q, out_rd_d;
  logic [1:0]            out_exc_q, out_exc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [1:0]            chk_exc;
  logic [DATA_WIDTH-1:0] st_masked;
  logic [DATA_WIDTH-1:0] ld_ext;

  ysyx_22050133_lsu_fmt #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fmt (
    .chk_addr  (bus.in_addr_i[2:0]),
    .chk_we    (bus.in_we_i),
    .chk_funct3(bus.in_funct3_i),
    .st_data   (bus.in_wdata_i),
    .exc       (chk_exc),
    .st_masked (st_masked),
    .ld_funct3 (funct3_q),
    .ld_raw    (bus.r_data_i),
    .ld_ext    (ld_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      rw_valid_q  <= 1'b0;
      rdy_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_rdata_q <= '0;
      out_rd_q    <= '0;
      out_exc_q   <= EXC_NONE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      rw_valid_q  <= rw_valid_d;
      rdy_q       <= rdy_d;
      out_valid_q <= out_valid_d;
      out_rdata_q <= out_rdata_d;
      out_rd_q    <= out_rd_d;
      out_exc_q   <= out_exc_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
    end
  end

  // Faulting ops skip the cache entirely and go straight to the result stage.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    rw_valid_d  = rw_valid_q;
    rdy_d       = rdy_q;
    out_valid_d = out_valid_q;
    out_rdata_d = out_rdata_q;
    out_rd_d    = out_rd_q;
    out_exc_d   = out_exc_q;
    addr_d      = addr_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid_i && in_ready_q) begin
          addr_d     = bus.in_addr_i;
          we_d       = bus.in_we_i;
          funct3_d   = bus.in_funct3_i;
          wdata_d    = st_masked;
          out_rd_d   = bus.in_rd_i;
          in_ready_d = 1'b0;
          if (chk_exc != EXC_NONE) begin
            out_valid_d = 1'b1;
            out_exc_d   = chk_exc;
            out_rdata_d = '0;
            state_d     = ST_RESP;
          end else begin
            rw_valid_d = 1'b1;
            out_exc_d  = EXC_NONE;
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.rw_addr_ready_i) begin
          rw_valid_d = 1'b0;
          rdy_d      = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.rw_data_valid_i && rdy_q) begin
          rdy_d       = 1'b0;
          out_valid_d = 1'b1;
          out_rdata_d = we_q ? '0 : ld_ext;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready_o      = in_ready_q;
  assign bus.out_valid_o     = out_valid_q;
  assign bus.out_rdata_o     = out_rdata_q;
  assign bus.out_rd_o        = out_rd_q;
  assign bus.out_exc_o       = out_exc_q;
  assign bus.rw_addr_valid_o = rw_valid_q;
  assign bus.rw_addr_o       = addr_q;
  assign bus.rw_we_o         = we_q;
  assign bus.rw_size_o       = {1'b0, funct3_q[1:0]};
  assign bus.rw_if_o         = 1'b0;
  assign bus.w_data_o        = wdata_q;
  assign bus.r_data_ready_o  = rdy_q;

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// Self-checking bench for ysyx_22050133_lsu: directed vector table, reset abort
// sequence, and random ops compared with an arithmetic reference model.
module tb_ysyx_22050133_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22050133_lsu_if bus ();

  ysyx_22050133_lsu dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [2:0]  f3;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [1:0]  exp_exc;
    logic [63:0] exp_rdata;
    logic [2:0]  exp_size;
    logic [63:0] exp_wdata;
    int          req_stall;
    int          data_lat;
    int          out_stall;
  } vec_t;

  function automatic vec_t mk(input logic [63:0] addr, input logic we, input logic [2:0] f3,
                              input logic [63:0] wdata, input logic [63:0] rdata,
                              input logic [1:0] exp_exc, input logic [63:0] exp_rdata,
                              input logic [2:0] exp_size, input logic [63:0] exp_wdata,
                              input int req_stall, input int data_lat, input int out_stall);
    vec_t v;
    v.addr = addr; v.we = we; v.f3 = f3; v.wdata = wdata; v.rdata = rdata;
    v.exp_exc = exp_exc; v.exp_rdata = exp_rdata; v.exp_size = exp_size; v.exp_wdata = exp_wdata;
    v.req_stall = req_stall; v.data_lat = data_lat; v.out_stall = out_stall;
    return v;
  endfunction

  // Reference model: access width in bytes drives everything.
  function automatic int ref_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] ref_mask(input int bytes);
    if (bytes == 8) return {64{1'b1}};
    return (64'd1 << (8 * bytes)) - 64'd1;
  endfunction

  function automatic logic [1:0] ref_exc(input logic [63:0] addr, input logic we, input logic [2:0] f3);
    if (f3 == 3'b111 || (we && f3[2])) return 2'b10;
    if ((addr % ref_bytes(f3)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] raw, input logic [2:0] f3);
    int bytes = ref_bytes(f3);
    logic [63:0] m = ref_mask(bytes);
    logic [63:0] v = raw & m;
    if (!f3[2] && bytes < 8 && v[8*bytes-1]) v = v | ~m;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input logic [4:0] rd, input string tag);
    check_output({tag, " in_ready before"}, 64'(bus.in_ready_o), 64'd1);
    bus.in_valid_i  = 1'b1;
    bus.in_addr_i   = v.addr;
    bus.in_we_i     = v.we;
    bus.in_funct3_i = v.f3;
    bus.in_wdata_i  = v.wdata;
    bus.in_rd_i     = rd;
    @(posedge clk); #1;
    bus.in_valid_i  = 1'b0;
    bus.in_addr_i   = {$urandom, $urandom};
    bus.in_we_i     = 1'($urandom);
    bus.in_funct3_i = 3'($urandom);
    bus.in_wdata_i  = {$urandom, $urandom};
    bus.in_rd_i     = 5'($urandom);
    check_output({tag, " in_ready after accept"}, 64'(bus.in_ready_o), 64'd0);
    if (v.exp_exc != 2'b00) begin
      check_output({tag, " exc out_valid"}, 64'(bus.out_valid_o), 64'd1);
      check_output({tag, " exc rw_addr_valid"}, 64'(bus.rw_addr_valid_o), 64'd0);
    end else begin
      for (int c = 0; c <= v.req_stall; c++) begin
        check_output({tag, " rw_addr_valid"}, 64'(bus.rw_addr_valid_o), 64'd1);
        check_output({tag, " rw_addr"}, bus.rw_addr_o, v.addr);
        check_output({tag, " rw_we"}, 64'(bus.rw_we_o), 64'(v.we));
        check_output({tag, " rw_size"}, 64'(bus.rw_size_o), 64'(v.exp_size));
        check_output({tag, " rw_if"}, 64'(bus.rw_if_o), 64'd0);
        if (v.we) check_output({tag, " w_data"}, bus.w_data_o, v.exp_wdata);
        check_output({tag, " out_valid in REQ"}, 64'(bus.out_valid_o), 64'd0);
        bus.rw_addr_ready_i = (c == v.req_stall);
        bus.rw_data_valid_i = (c != v.req_stall);
        bus.r_data_i        = {$urandom, $urandom};
        @(posedge clk); #1;
      end
      bus.rw_addr_ready_i = 1'b0;
      bus.rw_data_valid_i = 1'b0;
      check_output({tag, " rw_addr_valid dropped"}, 64'(bus.rw_addr_valid_o), 64'd0);
      check_output({tag, " r_data_ready"}, 64'(bus.r_data_ready_o), 64'd1);
      for (int c = 0; c < v.data_lat; c++) begin
        @(posedge clk); #1;
        check_output({tag, " out_valid in WAIT"}, 64'(bus.out_valid_o), 64'd0);
      end
      bus.rw_data_valid_i = 1'b1;
      bus.r_data_i        = v.rdata;
      @(posedge clk); #1;
      bus.rw_data_valid_i = 1'b0;
      bus.r_data_i        = {$urandom, $urandom};
      check_output({tag, " out_valid"}, 64'(bus.out_valid_o), 64'd1);
      check_output({tag, " r_data_ready dropped"}, 64'(bus.r_data_ready_o), 64'd0);
    end
    check_output({tag, " out_rdata"}, bus.out_rdata_o, v.exp_rdata);
    check_output({tag, " out_exc"}, 64'(bus.out_exc_o), 64'(v.exp_exc));
    check_output({tag, " out_rd"}, 64'(bus.out_rd_o), 64'(rd));
    for (int c = 0; c < v.out_stall; c++) begin
      bus.rw_data_valid_i = 1'b1;
      @(posedge clk); #1;
      bus.rw_data_valid_i = 1'b0;
      check_output({tag, " out_valid held"}, 64'(bus.out_valid_o), 64'd1);
      check_output({tag, " out_rdata held"}, bus.out_rdata_o, v.exp_rdata);
      check_output({tag, " in_ready held low"}, 64'(bus.in_ready_o), 64'd0);
      check_output({tag, " rw_addr_valid in RESP"}, 64'(bus.rw_addr_valid_o), 64'd0);
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check_output({tag, " out_valid dropped"}, 64'(bus.out_valid_o), 64'd0);
    check_output({tag, " in_ready back"}, 64'(bus.in_ready_o), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, " in_ready"}, 64'(bus.in_ready_o), 64'd1);
    check_output({tag, " out_valid"}, 64'(bus.out_valid_o), 64'd0);
    check_output({tag, " out_rdata"}, bus.out_rdata_o, 64'd0);
    check_output({tag, " out_rd"}, 64'(bus.out_rd_o), 64'd0);
    check_output({tag, " out_exc"}, 64'(bus.out_exc_o), 64'd0);
    check_output({tag, " rw_addr_valid"}, 64'(bus.rw_addr_valid_o), 64'd0);
    check_output({tag, " rw_addr"}, bus.rw_addr_o, 64'd0);
    check_output({tag, " rw_we"}, 64'(bus.rw_we_o), 64'd0);
    check_output({tag, " rw_size"}, 64'(bus.rw_size_o), 64'd0);
    check_output({tag, " w_data"}, bus.w_data_o, 64'd0);
    check_output({tag, " r_data_ready"}, 64'(bus.r_data_ready_o), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[18];
    vec_t rv;
    logic [2:0] f3;
    int bytes;

    tbl[0]  = mk(64'h80000003, 0, 3'b000, 64'h0, 64'h0000000000000080, 2'b00, 64'hFFFFFFFFFFFFFF80, 3'd0, 64'h0, 0, 0, 0);
    tbl[1]  = mk(64'h80000004, 0, 3'b110, 64'h0, 64'hDEADBEEF87654321, 2'b00, 64'h0000000087654321, 3'd2, 64'h0, 1, 2, 0);
    tbl[2]  = mk(64'h80000004, 0, 3'b010, 64'h0, 64'hDEADBEEF87654321, 2'b00, 64'hFFFFFFFF87654321, 3'd2, 64'h0, 0, 1, 1);
    tbl[3]  = mk(64'h80000002, 1, 3'b001, 64'h1122334455667788, 64'hFFFFFFFFFFFFFFFF, 2'b00, 64'h0, 3'd1, 64'h7788, 0, 0, 0);
    tbl[4]  = mk(64'h80000001, 0, 3'b001, 64'h0, 64'h0, 2'b01, 64'h0, 3'd1, 64'h0, 0, 0, 1);
    tbl[5]  = mk(64'h80000000, 0, 3'b111, 64'h0, 64'h0, 2'b10, 64'h0, 3'd3, 64'h0, 0, 0, 0);
    tbl[6]  = mk(64'h80000001, 0, 3'b111, 64'h0, 64'h0, 2'b10, 64'h0, 3'd3, 64'h0, 0, 0, 0);
    tbl[7]  = mk(64'h80000000, 1, 3'b100, 64'hAB, 64'h0, 2'b10, 64'h0, 3'd0, 64'h0, 0, 0, 0);
    tbl[8]  = mk(64'h80000004, 0, 3'b011, 64'h0, 64'h0, 2'b01, 64'h0, 3'd3, 64'h0, 0, 0, 0);
    tbl[9]  = mk(64'h80000008, 0, 3'b011, 64'h0, 64'h8000000000000001, 2'b00, 64'h8000000000000001, 3'd3, 64'h0, 3, 0, 2);
    tbl[10] = mk(64'h80000006, 0, 3'b101, 64'h0, 64'h12345678ABCD8001, 2'b00, 64'h0000000000008001, 3'd1, 64'h0, 0, 0, 0);
    tbl[11] = mk(64'h80000006, 0, 3'b001, 64'h0, 64'h12345678ABCD8001, 2'b00, 64'hFFFFFFFFFFFF8001, 3'd1, 64'h0, 1, 0, 0);
    tbl[12] = mk(64'h80000010, 1, 3'b011, 64'h0102030405060708, 64'h5555, 2'b00, 64'h0, 3'd3, 64'h0102030405060708, 0, 3, 0);
    tbl[13] = mk(64'h80000004, 1, 3'b010, 64'h1122334455667788, 64'h0, 2'b00, 64'h0, 3'd2, 64'h0000000055667788, 2, 0, 0);
    tbl[14] = mk(64'h80000007, 0, 3'b100, 64'h0, 64'hFFFFFFFFFFFFFFF0, 2'b00, 64'h00000000000000F0, 3'd0, 64'h0, 0, 0, 0);
    tbl[15] = mk(64'h80000006, 0, 3'b010, 64'h0, 64'h0, 2'b01, 64'h0, 3'd2, 64'h0, 0, 0, 0);
    tbl[16] = mk(64'h80000002, 1, 3'b010, 64'h0, 64'h0, 2'b01, 64'h0, 3'd2, 64'h0, 0, 0, 0);
    tbl[17] = mk(64'h80000000, 1, 3'b101, 64'h0, 64'h0, 2'b10, 64'h0, 3'd1, 64'h0, 0, 0, 0);

    bus.in_valid_i = 0; bus.in_addr_i = '0; bus.in_we_i = 0; bus.in_funct3_i = '0;
    bus.in_wdata_i = '0; bus.in_rd_i = '0; bus.out_ready_i = 0;
    bus.rw_addr_ready_i = 0; bus.rw_data_valid_i = 0; bus.r_data_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // out_ready with nothing pending must not disturb an idle unit.
    bus.out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    check_output("early out_ready out_valid", 64'(bus.out_valid_o), 64'd0);
    check_output("early out_ready in_ready", 64'(bus.in_ready_o), 64'd1);

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(tbl[i], 5'(i + 1), $sformatf("vec%0d", i));
    end

    // Reset arriving mid-WAIT aborts the op without waiting for a clock edge.
    bus.in_valid_i = 1'b1; bus.in_addr_i = 64'h80000008; bus.in_we_i = 1'b0;
    bus.in_funct3_i = 3'b011; bus.in_rd_i = 5'd9;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.rw_addr_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rw_addr_ready_i = 1'b0;
    check_output("rst-seq r_data_ready", 64'(bus.r_data_ready_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    apply_stimulus(mk(64'h80000020, 0, 3'b000, 64'h0, 64'h7F, 2'b00, 64'h7F, 3'd0, 64'h0, 0, 1, 0),
                   5'd7, "post-reset");

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      rv.addr = 64'h80000000 + 64'($urandom_range(0, 63));
      rv.we = 1'($urandom_range(0, 1));
      rv.f3 = f3;
      rv.wdata = {$urandom, $urandom};
      rv.rdata = {$urandom, $urandom};
      bytes = ref_bytes(f3);
      rv.exp_exc = ref_exc(rv.addr, rv.we, f3);
      rv.exp_rdata = (rv.exp_exc != 2'b00 || rv.we) ? 64'h0 : ref_load(rv.rdata, f3);
      rv.exp_size = 3'(f3[1:0]);
      rv.exp_wdata = rv.wdata & ref_mask(bytes);
      rv.req_stall = $urandom_range(0, 3);
      rv.data_lat = $urandom_range(0, 3);
      rv.out_stall = $urandom_range(0, 2);
      apply_stimulus(rv, 5'($urandom), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050133_lsu.md
Name: ysyx_22050133_lsu

Overview:
Load/store unit that sits directly upstream of the data cache and drives its CPU-side rw request/response interface.
- Accepts one memory op per transaction from EXU; checks alignment and size legality.
- Issues a single-beat cache request; formats the returned load data with sign/zero extension.
- Hands the result to WBU through a valid/ready register stage. One op in flight; no speculation.

Parameters:
ADDR_WIDTH, 64, address width on both sides
DATA_WIDTH, 64, load/store data width
RD_WIDTH, 5, destination-register tag carried through

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid_i  in  1  EXU op valid
in_ready_o  out  1  LSU can accept an op
in_addr_i  in  ADDR_WIDTH  effective address
in_we_i  in  1  1=store, 0=load
in_funct3_i  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
in_wdata_i  in  DATA_WIDTH  store data, low-aligned
in_rd_i  in  RD_WIDTH  destination tag
out_valid_o  out  1  result valid to WBU
out_ready_i  in  1  WBU accepts result
out_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and exceptions
out_rd_o  out  RD_WIDTH  latched tag
out_exc_o  out  2  00 none, 01 misaligned, 10 illegal funct3
rw_addr_valid_o  out  1  cache request valid
rw_addr_ready_i  in  1  cache accepts request
rw_addr_o  out  ADDR_WIDTH  request address
rw_we_o  out  1  write enable
rw_size_o  out  3  AXI size code (= funct3[1:0] zero-extended)
rw_if_o  out  1  instruction-fetch flag, constant 0
w_data_o  out  DATA_WIDTH  store data, low-aligned; bits above the size are zeroed
rw_data_valid_i  in  1  cache completion (load data or store ack)
r_data_ready_o  out  1  LSU ready for completion
r_data_i  in  DATA_WIDTH  load data, already shifted to bit 0 by the cache

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: state IDLE, in_ready_o=1, all other outputs 0, all latches 0.
- States: IDLE, REQ, WAIT, RESP. Every output is registered.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&in_ready_o, latch addr, we, funct3, wdata and rd; drop in_ready_o.
  - If the op is illegal or misaligned: go to RESP with out_valid_o=1, out_exc_o set, out_rdata_o=0. No cache request is issued.
  - Otherwise: go to REQ with rw_addr_valid_o=1 and the rw_* fields driven from the latches.
- Illegal ops: funct3=111, or a store with funct3[2]=1. Illegal takes priority over misaligned.
- Misaligned ops: h with addr[0]!=0; w/wu with addr[1:0]!=0; d with addr[2:0]!=0.
- REQ:
  - Hold rw_addr_valid_o and all rw_* fields stable until rw_addr_ready_i is high.
  - On the handshake: drop rw_addr_valid_o, set r_data_ready_o=1, go to WAIT.
- WAIT:
  - On rw_data_valid_i&r_data_ready_o: drop r_data_ready_o, set out_valid_o=1, go to RESP.
  - Load result: r_data_i masked to the access size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1).
  - Store result: out_rdata_o=0.
- Completion outside WAIT: rw_data_valid_i is ignored in IDLE, REQ and RESP (r_data_ready_o is low there).
- RESP:
  - Hold out_* until out_ready_i is high; then drop out_valid_o, raise in_ready_o, go to IDLE.
  - out_ready_i asserted before out_valid_o has no effect.
- Latency and throughput:
  - Minimum latency, accept to out_valid_o: 3 cycles plus cache latency. Exception path: 1 cycle.
  - No back-to-back accept; in_ready_o returns the cycle after the out handshake.
- Changes on in_* after acceptance are ignored.
- Reset mid-operation aborts immediately to IDLE. The cache shares rst, so no orphan handshake survives.

Decomposition:
- Package ysyx_22050133_lsu_pkg holds:
  - funct3 encodings;
  - exc codes;
  - state enum;
  - the shared ysyx_22050133_AXI_SIZE_BYTES_1/2/4/8 constants.
- Sub-module ysyx_22050133_lsu_fmt is natural: combinational store masking, load extraction/extension, and the legality/alignment check.

Test Plan:
- LB, addr 0x80000003, r_data_i=0x...0080 -> rw_size_o=0, out_rdata_o=0xFFFFFFFFFFFFFF80, out_exc_o=00.
- LWU, addr 0x80000004, r_data_i=0xDEADBEEF_87654321 -> out_rdata_o=0x0000000087654321; same op with LW -> 0xFFFFFFFF87654321.
- SH, addr 0x80000002, in_wdata_i=0x1122334455667788 -> rw_we_o=1, rw_size_o=1, w_data_o=0x7788; after ack, out_rdata_o=0.
- LH at 0x80000001 -> rw_addr_valid_o never rises, out_valid_o one cycle after accept, out_exc_o=01; funct3=111 -> out_exc_o=10.
- rw_addr_ready_i held low 3 cycles and out_ready_i low 2 cycles -> rw_* and out_* stay stable; in_ready_o stays low until the out handshake.
- rst pulsed during WAIT -> all outputs return to reset values asynchronously; the next op completes normally.
